// File: rtl/npcg_toggle_mnc_n_init_multi_pkg.sv
// rtl/npcg_toggle_mnc_n_init_multi_pkg.sv - shared constants and state encoding for the NAND init sequencer
package npcg_toggle_mnc_n_init_multi_pkg;

    localparam logic [5:0] INIT_OPCODE    = 6'b101100;
    localparam logic [4:0] INIT_TARGET_ID = 5'b00101;

    localparam int PCMD_CAL_BIT   = 3;
    localparam int PCMD_TIMER_BIT = 0;
    localparam logic [7:0] PCMD_NONE  = 8'h00;
    localparam logic [7:0] PCMD_CAL   = 8'b1 << PCMD_CAL_BIT;
    localparam logic [7:0] PCMD_TIMER = 8'b1 << PCMD_TIMER_BIT;

    localparam logic [7:0] CMD_RESET_FF = 8'hFF;
    localparam logic [7:0] CMD_RESET_FC = 8'hFC;
    localparam logic [7:0] CMD_RESET_FA = 8'hFA;

    localparam logic [2:0] TIMER_OPTION = 3'b001;

    localparam logic [1:0] MODE_FC = 2'b01;
    localparam logic [1:0] MODE_FA = 2'b10;

    typedef enum logic [8:0] {
        S_RESET   = 9'b000000001,
        S_READY   = 9'b000000010,
        S_CAL_REQ = 9'b000000100,
        S_CAL_D0  = 9'b000001000,
        S_CAL_D1  = 9'b000010000,
        S_TM_REQ  = 9'b000100000,
        S_TM_WAIT = 9'b001000000,
        S_NEXT    = 9'b010000000,
        S_DONE    = 9'b100000000
    } state_t;

    // Mode 2'b11 deliberately falls back to the plain FFh reset.
    function automatic logic [7:0] reset_byte(input logic [1:0] mode);
        case (mode)
            MODE_FC: reset_byte = CMD_RESET_FC;
            MODE_FA: reset_byte = CMD_RESET_FA;
            default: reset_byte = CMD_RESET_FF;
        endcase
    endfunction

endpackage

// File: rtl/npcg_way_iter.sv
// rtl/npcg_way_iter.sv - lowest-set-bit selector and remaining-way bookkeeping for a way mask
module npcg_way_iter #(
    parameter int Width = 4
) (
    input  logic [Width-1:0] mask,
    output logic [Width-1:0] lowest,
    output logic [Width-1:0] cleared,
    output logic             any
);

    assign lowest  = mask & (~mask + Width'(1));
    assign cleared = mask & ~lowest;
    assign any     = |mask;

endmodule

// File: rtl/npcg_toggle_mnc_n_init_multi.sv
// rtl/npcg_toggle_mnc_n_init_multi.sv - Toggle MNC reset + timer-loop initialisation sequencer
module npcg_toggle_mnc_n_init_multi
    import npcg_toggle_mnc_n_init_multi_pkg::*;
#(
    parameter int NumberOfWays = 4,
    parameter int LoopCount    = 10,
    parameter int LoopCntWidth = 4,
    parameter int TimerCycles  = 99
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic [5:0]              iOpcode,
    input  logic [4:0]              iTargetID,
    input  logic [4:0]              iSourceID,
    input  logic                    iCMDValid,
    output logic                    oCMDReady,
    input  logic [NumberOfWays-1:0] iWaySelect,
    input  logic [1:0]              iResetMode,
    input  logic [7:0]              iLUNAddress,
    input  logic                    iSequential,
    output logic                    oStart,
    output logic                    oLastStep,
    input  logic [7:0]              iPM_Ready,
    input  logic [7:0]              iPM_LastStep,
    output logic [7:0]              oPM_PCommand,
    output logic [2:0]              oPM_PCommandOption,
    output logic [NumberOfWays-1:0] oPM_TargetWay,
    output logic [15:0]             oPM_NumOfData,
    output logic                    oPM_CASelect,
    output logic [7:0]              oPM_CAData
);

    localparam logic [LoopCntWidth-1:0] LOOP_LAST = LoopCntWidth'(LoopCount - 1);
    localparam logic [15:0]             TIMER_NUM = 16'(TimerCycles);

    state_t                  state;
    logic [4:0]              src_id;
    logic [NumberOfWays-1:0] way_mask;
    logic [1:0]              mode;
    logic [7:0]              lun;
    logic                    seq;
    logic [LoopCntWidth-1:0] loop_cnt;

    logic                    pm_ready;
    logic                    pcg_start;
    logic [NumberOfWays-1:0] iter_mask;
    logic [NumberOfWays-1:0] iter_lowest;
    logic [NumberOfWays-1:0] iter_cleared;
    logic                    iter_any;
    logic                    unused_bits;

    assign pm_ready  = iPM_Ready[5:0] == 6'h3F;
    assign pcg_start = (iOpcode == INIT_OPCODE) && (iTargetID == INIT_TARGET_ID) && iCMDValid;
    assign oStart    = pcg_start && (state == S_READY);
    assign oLastStep = state == S_DONE;

    // The requester ID is kept for the dispatcher's bookkeeping but never leaves this block.
    assign unused_bits = ^{src_id, iPM_Ready[7:6], iPM_LastStep[7:1]};

    // In READY the iterator looks at the incoming mask so the first target is known at acceptance.
    assign iter_mask = (state == S_READY) ? iWaySelect : way_mask;

    npcg_way_iter #(.Width(NumberOfWays)) u_way_iter (
        .mask    (iter_mask),
        .lowest  (iter_lowest),
        .cleared (iter_cleared),
        .any     (iter_any)
    );

    always_ff @(posedge iSystemClock or posedge iReset) begin
        if (iReset) begin
            state              <= S_RESET;
            src_id             <= '0;
            way_mask           <= '0;
            mode               <= '0;
            lun                <= '0;
            seq                <= 1'b0;
            loop_cnt           <= '0;
            oCMDReady          <= 1'b0;
            oPM_PCommand       <= PCMD_NONE;
            oPM_PCommandOption <= '0;
            oPM_TargetWay      <= '0;
            oPM_NumOfData      <= '0;
            oPM_CASelect       <= 1'b0;
            oPM_CAData         <= '0;
        end else begin
            case (state)
                S_RESET: begin
                    state     <= S_READY;
                    oCMDReady <= 1'b1;
                end
                S_READY: begin
                    if (pcg_start) begin
                        oCMDReady <= 1'b0;
                        src_id    <= iSourceID;
                        way_mask  <= iWaySelect;
                        mode      <= iResetMode;
                        lun       <= iLUNAddress;
                        seq       <= iSequential;
                        loop_cnt  <= '0;
                        if (!iter_any) begin
                            state <= S_DONE;
                        end else begin
                            state         <= S_CAL_REQ;
                            oPM_PCommand  <= PCMD_CAL;
                            oPM_NumOfData <= (iResetMode == MODE_FA) ? 16'd1 : 16'd0;
                            oPM_TargetWay <= iSequential ? iter_lowest : iWaySelect;
                        end
                    end
                end
                S_CAL_REQ: begin
                    if (pm_ready) begin
                        state         <= S_CAL_D0;
                        oPM_PCommand  <= PCMD_NONE;
                        oPM_NumOfData <= '0;
                        oPM_CASelect  <= 1'b0;
                        oPM_CAData    <= reset_byte(mode);
                    end
                end
                S_CAL_D0, S_CAL_D1: begin
                    if (state == S_CAL_D0 && mode == MODE_FA) begin
                        state        <= S_CAL_D1;
                        oPM_CASelect <= 1'b1;
                        oPM_CAData   <= lun;
                    end else begin
                        state              <= S_TM_REQ;
                        oPM_CASelect       <= 1'b0;
                        oPM_CAData         <= '0;
                        oPM_PCommand       <= PCMD_TIMER;
                        oPM_PCommandOption <= TIMER_OPTION;
                        oPM_NumOfData      <= TIMER_NUM;
                    end
                end
                S_TM_REQ: begin
                    if (pm_ready) begin
                        state              <= S_TM_WAIT;
                        oPM_PCommand       <= PCMD_NONE;
                        oPM_PCommandOption <= '0;
                        oPM_NumOfData      <= '0;
                    end
                end
                S_TM_WAIT: begin
                    if (iPM_LastStep[0]) begin
                        if (loop_cnt == LOOP_LAST) begin
                            state         <= S_NEXT;
                            oPM_TargetWay <= '0;
                            if (seq) way_mask <= iter_cleared;
                        end else begin
                            state              <= S_TM_REQ;
                            loop_cnt           <= loop_cnt + 1'b1;
                            oPM_PCommand       <= PCMD_TIMER;
                            oPM_PCommandOption <= TIMER_OPTION;
                            oPM_NumOfData      <= TIMER_NUM;
                        end
                    end
                end
                S_NEXT: begin
                    loop_cnt <= '0;
                    // Served bit was already dropped on leaving TM_WAIT, so any set bit is still pending.
                    if (seq && iter_any) begin
                        state         <= S_CAL_REQ;
                        oPM_PCommand  <= PCMD_CAL;
                        oPM_NumOfData <= (mode == MODE_FA) ? 16'd1 : 16'd0;
                        oPM_TargetWay <= iter_lowest;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state     <= S_READY;
                    oCMDReady <= 1'b1;
                end
                default: begin
                    state              <= S_READY;
                    loop_cnt           <= '0;
                    oCMDReady          <= 1'b1;
                    oPM_PCommand       <= PCMD_NONE;
                    oPM_PCommandOption <= '0;
                    oPM_TargetWay      <= '0;
                    oPM_NumOfData      <= '0;
                    oPM_CASelect       <= 1'b0;
                    oPM_CAData         <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npcg_toggle_mnc_n_init_multi.sv
// tb/tb_npcg_toggle_mnc_n_init_multi.sv - directed self-checking bench for the NAND init sequencer
module tb_npcg_toggle_mnc_n_init_multi;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [4:0]  target_id;
    logic [4:0]  source_id;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  way_select;
    logic [1:0]  reset_mode;
    logic [7:0]  lun_address;
    logic        sequential;
    logic        start;
    logic        last_step;
    logic [7:0]  pm_ready;
    logic [7:0]  pm_last_step;
    logic [7:0]  pm_pcommand;
    logic [2:0]  pm_option;
    logic [3:0]  pm_target_way;
    logic [15:0] pm_num_of_data;
    logic        pm_ca_select;
    logic [7:0]  pm_ca_data;

    int checks;
    int failures;

    int          cal_cnt;
    int          tm_cnt;
    int          done_cnt;
    logic [15:0] last_tm_num;
    logic [2:0]  last_tm_opt;
    logic [3:0]  cal_log [64];

    npcg_toggle_mnc_n_init_multi dut (
        .iSystemClock       (clk),
        .iReset             (rst),
        .iOpcode            (opcode),
        .iTargetID          (target_id),
        .iSourceID          (source_id),
        .iCMDValid          (cmd_valid),
        .oCMDReady          (cmd_ready),
        .iWaySelect         (way_select),
        .iResetMode         (reset_mode),
        .iLUNAddress        (lun_address),
        .iSequential        (sequential),
        .oStart             (start),
        .oLastStep          (last_step),
        .iPM_Ready          (pm_ready),
        .iPM_LastStep       (pm_last_step),
        .oPM_PCommand       (pm_pcommand),
        .oPM_PCommandOption (pm_option),
        .oPM_TargetWay      (pm_target_way),
        .oPM_NumOfData      (pm_num_of_data),
        .oPM_CASelect       (pm_ca_select),
        .oPM_CAData         (pm_ca_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cal_cnt     = 0;
        tm_cnt      = 0;
        done_cnt    = 0;
        last_tm_num = '0;
        last_tm_opt = '0;
    end

    // PM-side observer: counts commands the PM would actually accept.
    always @(negedge clk) begin
        if (pm_pcommand == 8'h08 && pm_ready[5:0] == 6'h3F) begin
            cal_log[cal_cnt % 64] = pm_target_way;
            cal_cnt = cal_cnt + 1;
        end
        if (pm_pcommand == 8'h01 && pm_ready[5:0] == 6'h3F) begin
            tm_cnt      = tm_cnt + 1;
            last_tm_num = pm_num_of_data;
            last_tm_opt = pm_option;
        end
        if (last_step === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        assert (observed === expected) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic issue(input logic [3:0] mask, input logic [1:0] mode, input logic [7:0] lun, input logic seq);
        opcode      = 6'b101100;
        target_id   = 5'b00101;
        source_id   = 5'd7;
        way_select  = mask;
        reset_mode  = mode;
        lun_address = lun;
        sequential  = seq;
        cmd_valid   = 1'b1;
        #1;
        chk("start_pulse", 32'(start), 32'd1);
        step();
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_last(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (last_step === 1'b1) seen = 1'b1;
            else step();
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    int cal_base, tm_base, done_base;

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        opcode       = '0;
        target_id    = '0;
        source_id    = '0;
        cmd_valid    = 1'b0;
        way_select   = '0;
        reset_mode   = '0;
        lun_address  = '0;
        sequential   = 1'b0;
        pm_ready     = 8'hFF;
        pm_last_step = 8'h01;

        repeat (3) step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_pcommand", 32'(pm_pcommand), 32'd0);
        chk("rst_last_step", 32'(last_step), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // 1: broadcast FFh, mask 1011
        cal_base = cal_cnt; tm_base = tm_cnt; done_base = done_cnt;
        issue(4'b1011, 2'b00, 8'h00, 1'b0);
        chk("t1_cal_cmd", 32'(pm_pcommand), 32'h08);
        chk("t1_cal_way", 32'(pm_target_way), 32'hB);
        chk("t1_cal_num", 32'(pm_num_of_data), 32'd0);
        chk("t1_busy", 32'(cmd_ready), 32'd0);
        step();
        chk("t1_ca_sel", 32'(pm_ca_select), 32'd0);
        chk("t1_ca_data", 32'(pm_ca_data), 32'hFF);
        wait_last("t1_done", 200);
        step();
        chk("t1_last_once", 32'(last_step), 32'd0);
        chk("t1_ready_back", 32'(cmd_ready), 32'd1);
        chk("t1_cal_count", 32'(cal_cnt - cal_base), 32'd1);
        chk("t1_tm_count", 32'(tm_cnt - tm_base), 32'd10);
        chk("t1_tm_num", 32'(last_tm_num), 32'd99);
        chk("t1_tm_opt", 32'(last_tm_opt), 32'd1);
        chk("t1_done_count", 32'(done_cnt - done_base), 32'd1);

        // 2: FAh with LUN 02
        issue(4'b0001, 2'b10, 8'h02, 1'b0);
        chk("t2_cal_num", 32'(pm_num_of_data), 32'd1);
        step();
        chk("t2_d0_sel", 32'(pm_ca_select), 32'd0);
        chk("t2_d0_data", 32'(pm_ca_data), 32'hFA);
        step();
        chk("t2_d1_sel", 32'(pm_ca_select), 32'd1);
        chk("t2_d1_data", 32'(pm_ca_data), 32'h02);
        step();
        chk("t2_tm_cmd", 32'(pm_pcommand), 32'h01);
        chk("t2_tm_num", 32'(pm_num_of_data), 32'd99);
        wait_last("t2_done", 200);
        step();

        // 3: sequential, mask 0110
        cal_base = cal_cnt; tm_base = tm_cnt;
        issue(4'b0110, 2'b00, 8'h00, 1'b1);
        chk("t3_first_way", 32'(pm_target_way), 32'h2);
        wait_last("t3_done", 400);
        step();
        chk("t3_cal_count", 32'(cal_cnt - cal_base), 32'd2);
        chk("t3_tm_count", 32'(tm_cnt - tm_base), 32'd20);
        chk("t3_way_a", 32'(cal_log[cal_base % 64]), 32'h2);
        chk("t3_way_b", 32'(cal_log[(cal_base + 1) % 64]), 32'h4);

        // 4: PM not ready for 5 cycles during CAL_REQ
        cal_base = cal_cnt;
        pm_ready = 8'h1F;
        issue(4'b0001, 2'b01, 8'h00, 1'b0);
        repeat (5) step();
        chk("t4_hold_cmd", 32'(pm_pcommand), 32'h08);
        chk("t4_no_ca", 32'(pm_ca_data), 32'h00);
        pm_ready = 8'hFF;
        step();
        chk("t4_ca_data", 32'(pm_ca_data), 32'hFC);
        wait_last("t4_done", 200);
        step();
        chk("t4_cal_count", 32'(cal_cnt - cal_base), 32'd1);

        // 5: empty mask
        cal_base = cal_cnt; tm_base = tm_cnt;
        issue(4'b0000, 2'b00, 8'h00, 1'b0);
        chk("t5_last", 32'(last_step), 32'd1);
        chk("t5_no_cmd", 32'(pm_pcommand), 32'd0);
        step();
        chk("t5_last_off", 32'(last_step), 32'd0);
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        chk("t5_no_pm", 32'((cal_cnt - cal_base) + (tm_cnt - tm_base)), 32'd0);

        // 6: reset while waiting on the timer
        pm_last_step = 8'h00;
        issue(4'b0001, 2'b00, 8'h00, 1'b0);
        repeat (3) step();
        chk("t6_in_wait", 32'(pm_pcommand), 32'd0);
        chk("t6_in_wait_busy", 32'(cmd_ready), 32'd0);
        done_base = done_cnt;
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", 32'({pm_target_way, pm_num_of_data, pm_ca_data, cmd_ready, last_step}), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("t6_ready", 32'(cmd_ready), 32'd1);
        chk("t6_no_last", 32'(done_cnt - done_base), 32'd0);
        pm_last_step = 8'h01;
        tm_base = tm_cnt;
        issue(4'b0100, 2'b00, 8'h00, 1'b0);
        chk("t6_new_way", 32'(pm_target_way), 32'h4);
        wait_last("t6_done", 200);
        step();
        chk("t6_tm_count", 32'(tm_cnt - tm_base), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npcg_toggle_mnc_n_init_multi.md
Name: npcg_toggle_mnc_n_init_multi

Overview:
Parametrised NAND initialisation sequencer for the Toggle MNC command path. On command opcode 6'b101100 with target ID 5'b00101 it issues a reset command, then a configurable number of timer loops, to the selected ways. It supports three reset flavours (FFh, FCh, FAh with LUN address) and two way modes (broadcast to all selected ways, or sequential one way at a time). It sits between the command dispatcher and the primitive-module (PM) bus, alongside the other NPCG_Toggle_MNC_* executors.

Parameters:
NumberOfWays, 4, number of way-select bits.
LoopCount, 10, timer loops per reset (must be 1..2^LoopCntWidth-1).
LoopCntWidth, 4, width of the loop counter.
TimerCycles, 99, value driven on oPM_NumOfData during timer commands.

Ports:
iSystemClock  in  1  clock
iReset  in  1  async reset, active-high
iOpcode  in  6  command opcode
iTargetID  in  5  command target
iSourceID  in  5  requester ID (captured, held internally)
iCMDValid  in  1  command valid
oCMDReady  out  1  ready for command
iWaySelect  in  NumberOfWays  target ways
iResetMode  in  2  00=FFh, 01=FCh, 10=FAh+LUN, 11=FFh
iLUNAddress  in  8  LUN address byte for FAh
iSequential  in  1  1=reset ways one at a time
oStart  out  1  command accepted (comb.)
oLastStep  out  1  one-cycle completion pulse (comb.)
iPM_Ready  in  8  PM ready bits
iPM_LastStep  in  8  PM last-step bits
oPM_PCommand  out  8  bit3=CAL, bit0=timer
oPM_PCommandOption  out  3  timer option
oPM_TargetWay  out  NumberOfWays  active way mask
oPM_NumOfData  out  16  CA byte count-1 / timer cycles
oPM_CASelect  out  1  0=command byte, 1=address byte
oPM_CAData  out  8  CA byte

Behaviour:
- Reset (async): FSM to RESET; all registered outputs 0; next cycle READY. Reset mid-operation aborts with no completion pulse.
- wPMReady = iPM_Ready[5:0]==6'h3F.
- wPCGStart = opcode/target match & iCMDValid. oStart = wPCGStart & state==READY.
- READY: oCMDReady=1, PM outputs 0. On wPCGStart, capture iSourceID, iWaySelect, iResetMode, iLUNAddress, iSequential; go to CAL_REQ. Exception: captured way mask 0 -> DONE.
- Active mask: broadcast = captured mask; sequential = one-hot of the lowest remaining set bit.
- CAL_REQ: PCommand=8'h08, NumOfData=0 (FFh/FCh) or 1 (FAh), TargetWay=active mask. Holds until wPMReady, then CAL_D0.
- CAL_D0 (1 cycle): PCommand=0, CASelect=0, CAData=FF/FC/FA per mode. Next state is CAL_D1 for FAh, else TM_REQ.
- CAL_D1 (1 cycle): CASelect=1, CAData=captured LUN; next TM_REQ.
- TM_REQ: PCommand=8'h01, Option=3'b001, NumOfData=TimerCycles. On wPMReady go to TM_WAIT.
- TM_WAIT: PCommand=0. On iPM_LastStep[0], loop counter +1.
  - If counter+1==LoopCount: go to NEXT.
  - Otherwise: go to TM_REQ.
- NEXT: loop counter cleared.
  - Sequential with remaining ways: clear the served bit and go to CAL_REQ.
  - Otherwise: go to DONE.
- DONE (1 cycle): oLastStep=1; next READY.
- Total PM CAL commands per command: 1 (broadcast) or popcount(mask) (sequential). Timer commands = LoopCount per CAL.
- Any illegal state -> READY.

Decomposition:
- Shared package: opcode/target constants (6'b101100, 5'b00101), PCommand bit positions, reset command bytes FFh/FCh/FAh, timer option 3'b001, state encoding (one-hot, 9 states).
- One natural sub-module: npcg_way_iter, which provides lowest-set-bit one-hot, clear-served-bit and an "any remaining" flag for the mask.

Test Plan:
1. Broadcast FFh, mask 4'b1011, LoopCount=10, PM always ready → one CAL with CAData FF and TargetWay 1011, then 10 timer commands with NumOfData 99, then oLastStep pulses exactly once.
2. FAh mode, LUN 8'h02 → NumOfData=1 during CAL_REQ; CA bytes FA (CASelect 0) then 02 (CASelect 1) on consecutive cycles.
3. Sequential, mask 4'b0110 → CAL+10 timer commands to way 0010, then to way 0100, then oLastStep; 2 CALs and 20 timer commands total.
4. iPM_Ready[5:0]=0x1F held 5 cycles during CAL_REQ → PCommand stays 8'h08, no CA data until ready; then proceeds normally.
5. Mask 0 → no PM commands; oLastStep pulses in the cycle after acceptance; oCMDReady returns to 1.
6. iReset asserted during TM_WAIT → all outputs 0 immediately, no oLastStep; READY two cycles after release; a new command completes normally.
